// File: rtl/ula_muldiv_ctrl.sv
// Iterative multiply/divide sequencer that time-shares an external combinational ula.
// Optional signed support: define MULDIV_SIGNED_EN (adds signed_op port and FIX state).
`timescale 1ns/1ps
module ula_muldiv_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       ula_ctrl,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    input  logic [WIDTH-1:0] ula_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef MULDIV_SIGNED_EN
        S_FIX  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;   // MUL: product high half, DIV: partial remainder
    logic [WIDTH-1:0] r_lo;   // MUL: multiplier/product low half, DIV: quotient
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;

    logic [WIDTH-1:0] w_a_ld;
    logic [WIDTH-1:0] w_b_ld;
    logic             w_mul_carry;
    logic [WIDTH-1:0] w_rs;
    logic             w_div_take;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

`ifdef MULDIV_SIGNED_EN
    logic                 r_sgn;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 w_sa;
    logic                 w_sb;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // Operands are reduced to magnitudes at load; signs are restored in FIX.
    assign w_sa   = signed_op & a[WIDTH-1];
    assign w_sb   = signed_op & b[WIDTH-1];
    assign w_a_ld = w_sa ? (~a + 1'b1) : a;
    assign w_b_ld = w_sb ? (~b + 1'b1) : b;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_neg = ~w_prod + 1'b1;

    always_comb begin
        w_fix_hi = r_hi;
        w_fix_lo = r_lo;
        if (r_op) begin
            if (r_neg_q) w_fix_lo = ~r_lo + 1'b1;
            if (r_neg_r) w_fix_hi = ~r_hi + 1'b1;
        end else if (r_neg_q) begin
            {w_fix_hi, w_fix_lo} = w_prod_neg;
        end
    end
`else
    assign w_a_ld = a;
    assign w_b_ld = b;
`endif

    // Multiply step: carry out of hi + addend is recovered by an unsigned wrap test.
    assign w_mul_carry = (ula_result < r_hi);
    // Divide step: shift next dividend bit into remainder; top bit forces subtract.
    assign w_rs        = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_div_take  = r_hi[WIDTH-1] | (w_rs >= r_b);

    always_comb begin
        if (r_op) begin
            w_hi_nxt = w_div_take ? ula_result : w_rs;
            w_lo_nxt = {r_lo[WIDTH-2:0], w_div_take};
        end else begin
            w_hi_nxt = {w_mul_carry, ula_result[WIDTH-1:1]};
            w_lo_nxt = {ula_result[0], r_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        ula_ctrl = 3'd0;
        ula_a    = '0;
        ula_b    = '0;
        if (r_state == S_RUN) begin
            if (r_op) begin
                ula_ctrl = 3'd6;
                ula_a    = w_rs;
                ula_b    = r_b;
            end else begin
                ula_ctrl = 3'd2;
                ula_a    = r_hi;
                ula_b    = r_lo[0] ? r_a : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
`ifdef MULDIV_SIGNED_EN
            r_sgn    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= w_a_ld;
                        r_b   <= w_b_ld;
                        r_dbz <= 1'b0;
                        r_cnt <= CW'(WIDTH);
`ifdef MULDIV_SIGNED_EN
                        r_sgn   <= signed_op;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
`endif
                        if (op && (b == '0)) begin
                            r_res_lo <= '1;
                            r_res_hi <= a;
                            r_dbz    <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= op ? w_a_ld : w_b_ld;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
`ifdef MULDIV_SIGNED_EN
                        if (r_sgn) r_state <= S_FIX;
                        else
`endif
                        begin
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_res_lo <= w_lo_nxt;
                            r_res_hi <= w_hi_nxt;
                            r_state  <= S_DONE;
                        end
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_FIX: begin
                    r_hi     <= w_fix_hi;
                    r_lo     <= w_fix_lo;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_res_lo <= w_fix_lo;
                    r_res_hi <= w_fix_hi;
                    r_state  <= S_DONE;
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result_lo   = r_res_lo;
    assign result_hi   = r_res_hi;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_ula_muldiv_ctrl.sv
// Directed self-checking bench for ula_muldiv_ctrl with a behavioural ula model.
`timescale 1ns/1ps
module tb_ula_muldiv_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
`ifdef MULDIV_SIGNED_EN
    logic         signed_op = 1'b0;
`endif
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   ula_ctrl;
    logic [W-1:0] ula_a;
    logic [W-1:0] ula_b;
    logic [W-1:0] ula_result;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    int pass_cnt = 0;
    int total_cnt = 0;
    int lat;
    int hits;

    ula_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
`ifdef MULDIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .a(a), .b(b), .ula_ctrl(ula_ctrl), .ula_a(ula_a), .ula_b(ula_b),
        .ula_result(ula_result), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // External ula: AND / ADD / SUB subset.
    always_comb begin
        case (ula_ctrl)
            3'd0:    ula_result = ula_a & ula_b;
            3'd2:    ula_result = ula_a + ula_b;
            3'd6:    ula_result = ula_a - ula_b;
            default: ula_result = '0;
        endcase
    end

    task automatic do_op(input logic iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output int olat, output int ohits);
        olat = -1;
        ohits = 0;
        @(negedge clk);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy && ula_ctrl == (iop ? 3'd6 : 3'd2)) ohits++;
            if (done) begin
                olat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if ({busy, done, div_by_zero, result_lo, result_hi, ula_ctrl} !== '0)
            $display("FAIL reset_state got busy=%b done=%b dbz=%b lo=%h hi=%h ctrl=%0d want all 0",
                     busy, done, div_by_zero, result_lo, result_hi, ula_ctrl);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        do_op(1'b0, 8'd13, 8'd11, lat, hits);
        total_cnt++;
        if (lat !== 9) $display("FAIL mul_latency got %0d want 9", lat); else pass_cnt++;
        total_cnt++;
        if (hits !== 8) $display("FAIL mul_ctrl_add_cycles got %0d want 8", hits); else pass_cnt++;
        total_cnt++;
        if ({result_hi, result_lo, div_by_zero} !== {8'h00, 8'h8F, 1'b0})
            $display("FAIL mul_13x11 got hi=%h lo=%h dbz=%b want 00 8f 0", result_hi, result_lo, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, busy} !== 2'b00) $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_mul_carry();
        do_op(1'b0, 8'hFF, 8'hFF, lat, hits);
        total_cnt++;
        if ({result_hi, result_lo} !== 16'hFE01)
            $display("FAIL mul_ffxff got %h%h want fe01", result_hi, result_lo);
        else pass_cnt++;
    endtask

    task automatic test_div();
        do_op(1'b1, 8'd200, 8'd7, lat, hits);
        total_cnt++;
        if (lat !== 9) $display("FAIL div_latency got %0d want 9", lat); else pass_cnt++;
        total_cnt++;
        if (hits !== 8) $display("FAIL div_ctrl_sub_cycles got %0d want 8", hits); else pass_cnt++;
        total_cnt++;
        if ({result_lo, result_hi, div_by_zero} !== {8'h1C, 8'h04, 1'b0})
            $display("FAIL div_200_7 got lo=%h hi=%h dbz=%b want 1c 04 0", result_lo, result_hi, div_by_zero);
        else pass_cnt++;
        do_op(1'b1, 8'hFF, 8'h01, lat, hits);
        total_cnt++;
        if ({result_lo, result_hi} !== 16'hFF00)
            $display("FAIL div_ff_1 got lo=%h hi=%h want ff 00", result_lo, result_hi);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        do_op(1'b1, 8'h55, 8'h00, lat, hits);
        total_cnt++;
        if (lat !== 1) $display("FAIL dbz_latency got %0d want 1", lat); else pass_cnt++;
        total_cnt++;
        if ({result_lo, result_hi, div_by_zero} !== {8'hFF, 8'h55, 1'b1})
            $display("FAIL dbz_result got lo=%h hi=%h dbz=%b want ff 55 1", result_lo, result_hi, div_by_zero);
        else pass_cnt++;
        do_op(1'b0, 8'd2, 8'd3, lat, hits);
        total_cnt++;
        if ({result_lo, result_hi, div_by_zero} !== {8'h06, 8'h00, 1'b0})
            $display("FAIL dbz_clear got lo=%h hi=%h dbz=%b want 06 00 0", result_lo, result_hi, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_protocol();
        int c;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 8'd13; b = 8'd11;
        @(posedge clk);
        #1 start = 1'b0;
        c = 0;
        repeat (3) begin @(negedge clk); c++; end
        start = 1'b1; op = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk); c++;
        start = 1'b0;
        while (!done && c < 40) begin @(negedge clk); c++; end
        total_cnt++;
        if (c !== 9) $display("FAIL ignore_start_latency got %0d want 9", c); else pass_cnt++;
        total_cnt++;
        if ({result_hi, result_lo} !== 16'h008F)
            $display("FAIL ignore_start_result got hi=%h lo=%h want 00 8f", result_hi, result_lo);
        else pass_cnt++;
        // start presented during DONE must not launch a new operation
        start = 1'b1; op = 1'b1; a = 8'd9; b = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, div_by_zero, result_lo} !== {1'b0, 1'b0, 1'b0, 8'h8F})
            $display("FAIL start_in_done got busy=%b done=%b dbz=%b lo=%h want 0 0 0 8f",
                     busy, done, div_by_zero, result_lo);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, div_by_zero, result_lo, result_hi, ula_ctrl} !== '0)
            $display("FAIL async_reset got busy=%b done=%b dbz=%b lo=%h hi=%h ctrl=%0d want all 0",
                     busy, done, div_by_zero, result_lo, result_hi, ula_ctrl);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 8'd2, 8'd3, lat, hits);
        total_cnt++;
        if (lat !== 9 || {result_hi, result_lo} !== 16'h0006)
            $display("FAIL after_reset got lat=%0d hi=%h lo=%h want 9 00 06", lat, result_hi, result_lo);
        else pass_cnt++;
    endtask

`ifdef MULDIV_SIGNED_EN
    task automatic test_signed();
        signed_op = 1'b1;
        do_op(1'b0, 8'hF9, 8'h03, lat, hits);
        total_cnt++;
        if (lat !== 10) $display("FAIL signed_latency got %0d want 10", lat); else pass_cnt++;
        total_cnt++;
        if ({result_hi, result_lo} !== 16'hFFEB)
            $display("FAIL signed_mul got %h%h want ffeb", result_hi, result_lo);
        else pass_cnt++;
        do_op(1'b1, 8'hF9, 8'h02, lat, hits);
        total_cnt++;
        if ({result_lo, result_hi} !== 16'hFDFF)
            $display("FAIL signed_div got lo=%h hi=%h want fd ff", result_lo, result_hi);
        else pass_cnt++;
        signed_op = 1'b0;
        do_op(1'b0, 8'hF9, 8'h03, lat, hits);
        total_cnt++;
        if (lat !== 9 || {result_hi, result_lo} !== 16'h02EB)
            $display("FAIL unsigned_in_signed_build got lat=%0d %h%h want 9 02eb", lat, result_hi, result_lo);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_carry();
        test_div();
        test_div_zero();
        test_protocol();
        test_reset_mid();
`ifdef MULDIV_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
